// File: rtl/softshell_pkg.sv
// Shared types and constants for the softshell Wishbone arbitration logic.
package softshell_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    localparam int unsigned WB_TIMEOUT_W = 16;

    // Index width for an N-entry requester set; a single requester still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/softshell_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
module softshell_rr_picker
    import softshell_pkg::*;
#(
    parameter int unsigned N = 3,
    localparam int unsigned IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             any_o,
    output logic [N-1:0]     onehot_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        int unsigned j;
        logic [IDX_W-1:0] cand;
        any_o    = 1'b0;
        onehot_o = '0;
        idx_o    = '0;
        j        = 0;
        cand     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            j = 32'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            cand = IDX_W'(j);
            if (!any_o && req_i[cand]) begin
                any_o           = 1'b1;
                idx_o           = cand;
                onehot_o[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/softshell_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing one slave fabric between NUM_MASTERS requesters,
// with a stall watchdog that answers err to the owner when the slave never acks.
module softshell_wb_arbiter
    import softshell_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 3,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                                 wb_clk_i,
    input  logic                                 wb_rst_i,
    input  logic [NUM_MASTERS-1:0]               m_cyc_i,
    input  logic [NUM_MASTERS-1:0]               m_stb_i,
    input  logic [NUM_MASTERS-1:0]               m_we_i,
    input  logic [NUM_MASTERS*(DATA_W/8)-1:0]    m_sel_i,
    input  logic [NUM_MASTERS*ADDR_W-1:0]        m_adr_i,
    input  logic [NUM_MASTERS*DATA_W-1:0]        m_dat_i,
    output logic [NUM_MASTERS-1:0]               m_ack_o,
    output logic [NUM_MASTERS-1:0]               m_err_o,
    output logic [DATA_W-1:0]                    m_dat_o,
    output logic                                 s_cyc_o,
    output logic                                 s_stb_o,
    output logic                                 s_we_o,
    output logic [(DATA_W/8)-1:0]                s_sel_o,
    output logic [ADDR_W-1:0]                    s_adr_o,
    output logic [DATA_W-1:0]                    s_dat_o,
    input  logic                                 s_ack_i,
    input  logic [DATA_W-1:0]                    s_dat_i,
    output logic [NUM_MASTERS-1:0]               grant_o,
    output logic                                 timeout_o
);

    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned IDX_W = idx_width(NUM_MASTERS);
    localparam logic [WB_TIMEOUT_W-1:0] WDOG_LAST = WB_TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e               state_q, state_d;
    logic [NUM_MASTERS-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]         owner_q, owner_d;
    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [WB_TIMEOUT_W-1:0]  wdog_q, wdog_d;

    logic                     pick_any;
    logic [NUM_MASTERS-1:0]   pick_onehot;
    logic [IDX_W-1:0]         pick_idx;

    logic                     own_cyc, own_stb, own_we;
    logic [SEL_W-1:0]         own_sel;
    logic [ADDR_W-1:0]        own_adr;
    logic [DATA_W-1:0]        own_dat;
    logic                     owned, stalled, fire;

    softshell_rr_picker #(
        .N (NUM_MASTERS)
    ) u_picker (
        .req_i    (m_cyc_i),
        .ptr_i    (rr_ptr_q),
        .any_o    (pick_any),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx)
    );

    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_sel = '0;
        own_adr = '0;
        own_dat = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (IDX_W'(i) == owner_q) begin
                own_cyc = m_cyc_i[i];
                own_stb = m_stb_i[i];
                own_we  = m_we_i[i];
                own_sel = m_sel_i[i*SEL_W +: SEL_W];
                own_adr = m_adr_i[i*ADDR_W +: ADDR_W];
                own_dat = m_dat_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Reset gates the bus in the same cycle so a late slave ack never leaks through.
    assign owned   = (state_q == OWNED) && !wb_rst_i;
    assign stalled = owned && own_stb && !s_ack_i;
    assign fire    = stalled && (wdog_q == WDOG_LAST);

    assign s_cyc_o   = owned & own_cyc;
    assign s_stb_o   = owned & own_stb;
    assign s_we_o    = owned & own_we;
    assign s_sel_o   = owned ? own_sel : '0;
    assign s_adr_o   = owned ? own_adr : '0;
    assign s_dat_o   = owned ? own_dat : '0;
    assign m_dat_o   = s_dat_i;
    assign m_ack_o   = grant_q & {NUM_MASTERS{owned & own_stb & s_ack_i}};
    assign m_err_o   = grant_q & {NUM_MASTERS{fire}};
    assign timeout_o = fire;
    assign grant_o   = grant_q;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        wdog_d   = wdog_q;
        case (state_q)
            IDLE: begin
                wdog_d = '0;
                if (pick_any) begin
                    state_d  = OWNED;
                    grant_d  = pick_onehot;
                    owner_d  = pick_idx;
                    rr_ptr_d = (pick_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : pick_idx + IDX_W'(1);
                end
            end
            OWNED: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                    wdog_d  = '0;
                end else if (stalled && !fire) begin
                    wdog_d = wdog_q + WB_TIMEOUT_W'(1);
                end else begin
                    wdog_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            wdog_q   <= wdog_d;
        end
    end

endmodule

// File: tb/tb_softshell_wb_arbiter.sv
// Self-checking bench for softshell_wb_arbiter: directed scenarios plus randomized
// traffic compared against a tenure-level reference model.
`timescale 1ns/1ps
module tb_softshell_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      m_cyc, m_stb, m_we;
    logic [N*SW-1:0]   m_sel;
    logic [N*AW-1:0]   m_adr;
    logic [N*DW-1:0]   m_dat;
    logic [N-1:0]      m_ack, m_err, grant;
    logic [DW-1:0]     mdat_o, s_dat_o, s_dat;
    logic              s_cyc, s_stb, s_we, s_ack, tmo;
    logic [SW-1:0]     s_sel;
    logic [AW-1:0]     s_adr;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    softshell_wb_arbiter #(
        .NUM_MASTERS    (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .m_cyc_i   (m_cyc),
        .m_stb_i   (m_stb),
        .m_we_i    (m_we),
        .m_sel_i   (m_sel),
        .m_adr_i   (m_adr),
        .m_dat_i   (m_dat),
        .m_ack_o   (m_ack),
        .m_err_o   (m_err),
        .m_dat_o   (mdat_o),
        .s_cyc_o   (s_cyc),
        .s_stb_o   (s_stb),
        .s_we_o    (s_we),
        .s_sel_o   (s_sel),
        .s_adr_o   (s_adr),
        .s_dat_o   (s_dat_o),
        .s_ack_i   (s_ack),
        .s_dat_i   (s_dat),
        .grant_o   (grant),
        .timeout_o (tmo)
    );

    // Reference model: who owns the bus, where round-robin resumes, how long the owner has stalled.
    int mdl_owner = -1;
    int mdl_ptr   = 0;
    int mdl_stall = 0;

    function automatic int first_req();
        for (int k = 0; k < N; k++) begin
            int j;
            j = (mdl_ptr + k) % N;
            if (m_cyc[j]) return j;
        end
        return -1;
    endfunction

    function automatic bit mdl_fire();
        if (mdl_owner < 0 || rst) return 1'b0;
        return m_stb[mdl_owner] && !s_ack && (mdl_stall == TO - 1);
    endfunction

    function automatic int next_owner();
        if (rst) return -1;
        if (mdl_owner < 0) return first_req();
        return m_cyc[mdl_owner] ? mdl_owner : -1;
    endfunction

    function automatic int next_ptr();
        int w;
        if (rst) return 0;
        if (mdl_owner >= 0) return mdl_ptr;
        w = first_req();
        return (w < 0) ? mdl_ptr : (w + 1) % N;
    endfunction

    function automatic int next_stall();
        if (rst || mdl_owner < 0 || !m_cyc[mdl_owner]) return 0;
        if (m_stb[mdl_owner] && !s_ack && !mdl_fire()) return mdl_stall + 1;
        return 0;
    endfunction

    always @(posedge clk) begin
        mdl_owner <= next_owner();
        mdl_ptr   <= next_ptr();
        mdl_stall <= next_stall();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0;
        m_adr = '0; m_dat = '0; s_ack = 1'b0; s_dat = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        vectors++; if (grant !== 3'b000) begin miscompares++; $display("FAIL reset_grant: got %b want 000", grant); end
        vectors++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin miscompares++; $display("FAIL reset_s_ctl: got %b want 000", {s_cyc, s_stb, s_we}); end
        vectors++; if ({s_adr, s_dat_o, s_sel} !== '0) begin miscompares++; $display("FAIL reset_s_bus: adr %h dat %h sel %h want 0", s_adr, s_dat_o, s_sel); end
        vectors++; if ({m_ack, m_err, tmo} !== '0) begin miscompares++; $display("FAIL reset_resp: ack %b err %b tmo %b want 0", m_ack, m_err, tmo); end
        tick();
    endtask

    task automatic test_single();
        do_reset();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
        m_adr[AW +: AW] = 32'h3000_0010; m_dat[DW +: DW] = 32'hCAFE_0001; m_sel[SW +: SW] = 4'hF;
        @(negedge clk);
        vectors++; if (s_cyc !== 1'b0) begin miscompares++; $display("FAIL single_idle_cyc: got %b want 0", s_cyc); end
        tick();
        @(negedge clk);
        vectors++; if (grant !== 3'b010) begin miscompares++; $display("FAIL single_grant: got %b want 010", grant); end
        vectors++; if (s_adr !== 32'h3000_0010) begin miscompares++; $display("FAIL single_adr: got %h want 30000010", s_adr); end
        vectors++; if ({s_cyc, s_stb, s_we} !== 3'b111) begin miscompares++; $display("FAIL single_ctl: got %b want 111", {s_cyc, s_stb, s_we}); end
        vectors++; if (s_dat_o !== 32'hCAFE_0001) begin miscompares++; $display("FAIL single_wdat: got %h want cafe0001", s_dat_o); end
        vectors++; if (m_ack !== 3'b000) begin miscompares++; $display("FAIL single_early_ack: got %b want 000", m_ack); end
        tick();
        s_ack = 1'b1; s_dat = 32'h1234_5678;
        @(negedge clk);
        vectors++; if (m_ack !== 3'b010) begin miscompares++; $display("FAIL single_ack: got %b want 010", m_ack); end
        vectors++; if (mdat_o !== 32'h1234_5678) begin miscompares++; $display("FAIL single_rdat: got %h want 12345678", mdat_o); end
        tick();
        s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        @(negedge clk);
        vectors++; if (m_ack !== 3'b000) begin miscompares++; $display("FAIL single_ack_once: got %b want 000", m_ack); end
        tick();
        @(negedge clk);
        vectors++; if (grant !== 3'b000) begin miscompares++; $display("FAIL single_release: got %b want 000", grant); end
        tick();
        clear_inputs();
    endtask

    task automatic test_contention();
        logic [N-1:0] exp_tr [11];
        logic [N-1:0] prev_ack;
        exp_tr = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010,
                   3'b000, 3'b100, 3'b100, 3'b000, 3'b001};
        prev_ack = '0;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            m_cyc = ~prev_ack;
            m_stb = m_cyc;
            s_ack = 1'b1;
            @(negedge clk);
            vectors++;
            if (grant !== exp_tr[c]) begin
                miscompares++;
                $display("FAIL contention_grant[%0d]: got %b want %b", c, grant, exp_tr[c]);
            end
            prev_ack = m_ack;
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back_burst();
        do_reset();
        m_cyc = 3'b101; m_stb = 3'b101; s_ack = 1'b1;
        @(negedge clk);
        vectors++; if (grant !== 3'b000) begin miscompares++; $display("FAIL burst_idle: got %b want 000", grant); end
        tick();
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            vectors++; if (grant !== 3'b001) begin miscompares++; $display("FAIL burst_grant[%0d]: got %b want 001", b, grant); end
            vectors++; if (m_ack !== 3'b001) begin miscompares++; $display("FAIL burst_ack[%0d]: got %b want 001", b, m_ack); end
            tick();
        end
        m_cyc = 3'b100; m_stb = 3'b100;
        @(negedge clk);
        vectors++; if ({grant, m_ack} !== 6'b001_000) begin miscompares++; $display("FAIL burst_drop: grant %b ack %b want 001 000", grant, m_ack); end
        tick();
        @(negedge clk);
        vectors++; if (grant !== 3'b000) begin miscompares++; $display("FAIL burst_dead: got %b want 000", grant); end
        tick();
        @(negedge clk);
        vectors++; if ({grant, m_ack} !== 6'b100_100) begin miscompares++; $display("FAIL burst_m2: grant %b ack %b want 100 100", grant, m_ack); end
        tick();
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        tick();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            vectors++;
            if (tmo !== (k == TO)) begin miscompares++; $display("FAIL timeout_pulse[%0d]: got %b want %b", k, tmo, (k == TO)); end
            vectors++;
            if (m_err !== ((k == TO) ? 3'b010 : 3'b000)) begin
                miscompares++; $display("FAIL timeout_err[%0d]: got %b want %b", k, m_err, (k == TO) ? 3'b010 : 3'b000);
            end
            vectors++; if (grant !== 3'b010) begin miscompares++; $display("FAIL timeout_hold[%0d]: got %b want 010", k, grant); end
            tick();
        end
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        tick();
        @(negedge clk);
        vectors++; if (grant !== 3'b000) begin miscompares++; $display("FAIL timeout_release: got %b want 000", grant); end
        tick();
    endtask

    task automatic test_ack_drop_race();
        do_reset();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        tick();
        tick();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack = 1'b1;
        @(negedge clk);
        vectors++; if (m_ack !== 3'b000) begin miscompares++; $display("FAIL race_ack: got %b want 000", m_ack); end
        tick();
        s_ack = 1'b0;
        @(negedge clk);
        vectors++; if ({grant, s_cyc} !== 4'b000_0) begin miscompares++; $display("FAIL race_idle: grant %b cyc %b want 000 0", grant, s_cyc); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_adr[2*AW +: AW] = 32'hDEAD_BEEF;
        tick();
        @(negedge clk);
        vectors++; if (grant !== 3'b100) begin miscompares++; $display("FAIL rstmid_grant: got %b want 100", grant); end
        tick();
        rst = 1'b1; s_ack = 1'b1;
        @(negedge clk);
        vectors++; if ({m_ack, s_cyc} !== 4'b000_0) begin miscompares++; $display("FAIL rstmid_ack: ack %b cyc %b want 000 0", m_ack, s_cyc); end
        tick();
        rst = 1'b0; clear_inputs();
        @(negedge clk);
        vectors++;
        if ({grant, s_cyc, s_stb, s_we, s_adr, m_ack, m_err, tmo} !== '0) begin
            miscompares++; $display("FAIL rstmid_outputs: grant %b cyc %b adr %h ack %b want all 0", grant, s_cyc, s_adr, m_ack);
        end
        // Leave the pointer at 1 via an m0 tenure, then check reset returns it to 0.
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; m_cyc = 3'b011; m_stb = 3'b011;
        tick();
        @(negedge clk);
        vectors++; if (grant !== 3'b001) begin miscompares++; $display("FAIL rstmid_ptr: got %b want 001", grant); end
        tick();
        clear_inputs();
    endtask

    task automatic test_random();
        logic [N-1:0]  eg, ea, ee;
        logic [2:0]    ectl;
        logic [AW-1:0] eadr;
        logic [DW-1:0] edat;
        logic [SW-1:0] esel;
        logic          act;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++) begin
                m_cyc[i] = m_cyc[i] ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
                m_stb[i] = m_cyc[i] & ($urandom_range(0, 3) != 0);
                m_we[i]  = 1'($urandom);
            end
            m_adr = {$urandom, $urandom, $urandom};
            m_dat = {$urandom, $urandom, $urandom};
            m_sel = 12'($urandom);
            s_ack = ($urandom_range(0, 2) == 0);
            s_dat = $urandom;
            @(negedge clk);
            act  = (mdl_owner >= 0) && !rst;
            eg   = (mdl_owner >= 0) ? (3'b001 << mdl_owner) : 3'b000;
            ectl = act ? {m_cyc[mdl_owner], m_stb[mdl_owner], m_we[mdl_owner]} : 3'b000;
            eadr = act ? m_adr[mdl_owner*AW +: AW] : '0;
            edat = act ? m_dat[mdl_owner*DW +: DW] : '0;
            esel = act ? m_sel[mdl_owner*SW +: SW] : '0;
            ea   = (act && s_ack && m_stb[mdl_owner]) ? eg : 3'b000;
            ee   = mdl_fire() ? eg : 3'b000;
            vectors++; if (grant !== eg) begin miscompares++; $display("FAIL rand_grant@%0d: got %b want %b", c, grant, eg); end
            vectors++; if ({s_cyc, s_stb, s_we} !== ectl) begin miscompares++; $display("FAIL rand_ctl@%0d: got %b want %b", c, {s_cyc, s_stb, s_we}, ectl); end
            vectors++; if (s_adr !== eadr) begin miscompares++; $display("FAIL rand_adr@%0d: got %h want %h", c, s_adr, eadr); end
            vectors++; if (s_dat_o !== edat) begin miscompares++; $display("FAIL rand_wdat@%0d: got %h want %h", c, s_dat_o, edat); end
            vectors++; if (s_sel !== esel) begin miscompares++; $display("FAIL rand_sel@%0d: got %h want %h", c, s_sel, esel); end
            vectors++; if (m_ack !== ea) begin miscompares++; $display("FAIL rand_ack@%0d: got %b want %b", c, m_ack, ea); end
            vectors++; if (m_err !== ee) begin miscompares++; $display("FAIL rand_err@%0d: got %b want %b", c, m_err, ee); end
            vectors++; if (tmo !== (ee != 0)) begin miscompares++; $display("FAIL rand_tmo@%0d: got %b want %b", c, tmo, (ee != 0)); end
            vectors++; if (mdat_o !== s_dat) begin miscompares++; $display("FAIL rand_rdat@%0d: got %h want %h", c, mdat_o, s_dat); end
            tick();
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_contention();
        test_back_to_back_burst();
        test_timeout();
        test_ack_drop_race();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/softshell_wb_arbiter.md
# softshell_wb_arbiter

Round-robin Wishbone arbiter that shares the single softshell slave-side interconnect between NUM_MASTERS requesters: the management SoC Wishbone port and the internal softshell cores. Sits between the user-project Wishbone slave port and the softshell peripheral/memory fabric. Grants one owner per bus tenure (held while the owner keeps `cyc` high), muxes its request onto the shared slave bus and routes responses back. A stall watchdog returns `err` if the slave never acks.

## Interface
- NUM_MASTERS, 3: number of requesters, 1..8; index 0 is the management SoC.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; SEL_W = DATA_W/8.
- TIMEOUT_CYCLES, 255: stall cycles without `ack` before `err`; 1..65535.

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- m_cyc_i  in  NUM_MASTERS  per-master cycle.
- m_stb_i  in  NUM_MASTERS  per-master strobe.
- m_we_i  in  NUM_MASTERS  per-master write enable.
- m_sel_i  in  NUM_MASTERS*SEL_W  byte selects; master i at slice [i*SEL_W +: SEL_W].
- m_adr_i  in  NUM_MASTERS*ADDR_W  addresses, same packing.
- m_dat_i  in  NUM_MASTERS*DATA_W  write data, same packing.
- m_ack_o  out  NUM_MASTERS  ack to the owner only.
- m_err_o  out  NUM_MASTERS  timeout error to the owner only.
- m_dat_o  out  DATA_W  read data, broadcast to all masters (valid only with that master's ack).
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave fabric.
- s_sel_o  out  SEL_W; s_adr_o out ADDR_W; s_dat_o out DATA_W  to slave fabric.
- s_ack_i  in  1  slave ack.
- s_dat_i  in  DATA_W  slave read data.
- grant_o  out  NUM_MASTERS  one-hot registered owner; all-zero when idle.
- timeout_o  out  1  one-cycle pulse when a watchdog timeout fires.

## Operation
- States: IDLE, OWNED.
- IDLE: when any `m_cyc_i` is high, select the first requester at or after `rr_ptr` (wrapping modulo NUM_MASTERS). Register `grant_o` to it and go to OWNED. Set `rr_ptr` to (winner+1) mod NUM_MASTERS.
- OWNED: all slave outputs are muxed from the owner's inputs; `s_cyc_o` = owner `m_cyc_i`, `s_stb_o` = owner `m_stb_i`.
  - `m_ack_o[owner]` = `s_ack_i` & owner stb.
  - Non-owners see ack/err at 0 and simply wait; they are not stalled by any other signal.
- Release: when the owner's `m_cyc_i` is low in OWNED, the next state is IDLE and `grant_o` clears. A new grant is issued from the following IDLE cycle, so there is always one dead cycle between tenures.
- Watchdog: a 16-bit counter increments each OWNED cycle with `s_stb_o`=1 and `s_ack_i`=0. It clears on ack, on leaving OWNED, or when owner stb is low.
  - On reaching TIMEOUT_CYCLES, `m_err_o[owner]` and `timeout_o` pulse for one cycle and the counter clears.
  - Grant is kept; the owner decides whether to drop `cyc`.
- Outside OWNED, all `s_*` outputs are 0.
- `m_dat_o` = `s_dat_i` combinationally.

## Timing
- Reset: `grant_o`=0, state IDLE, `rr_ptr`=0, watchdog=0. `s_cyc_o`, `s_stb_o`, `s_we_o`, `m_ack_o`, `m_err_o` and `timeout_o` are all 0. `s_adr_o`, `s_dat_o` and `s_sel_o` are 0.
- Reset mid-transfer drops the tenure immediately. A pending slave ack is not forwarded.
- Grant latency: a request first seen in cycle N in IDLE appears on `s_*` in cycle N+1.
- Ack path is combinational, zero added latency. A single transfer with a zero-wait slave costs one grant cycle plus one ack cycle.
- Owner drops `cyc` in the same cycle `s_ack_i` is high: the ack is gated off because stb is low, and the state still goes to IDLE.
- Simultaneous requests: strict round-robin from `rr_ptr`. A continuously requesting master waits at most NUM_MASTERS-1 tenures.
- If a watchdog timeout and `s_ack_i` occur in the same cycle, the ack wins; no err is raised.

## Structure
- Package `softshell_pkg`: the state enum (IDLE, OWNED) and `WB_TIMEOUT_W` = 16.
- One sub-module, `softshell_rr_picker`: combinational request vector plus pointer in, one-hot winner and index out. Reusable by the IO-pad mux.

## Test plan
- Single master: m1 holds `cyc`/`stb` with adr 0x3000_0010 and we=1; the slave acks 2 cycles after stb. Required: `s_adr_o`=0x3000_0010 one cycle after the request, `m_ack_o`=3'b010 for exactly one cycle, and `grant_o`=0 one cycle after `cyc` drops.
- Contention: all 3 masters request continuously with single-beat tenures and `rr_ptr`=0. Required: grant order 0,1,2,0, with one IDLE cycle between tenures.
- Locked burst: m0 keeps `cyc` high across 4 stb/ack beats while m2 requests. Required: m2 is granted only after m0 drops `cyc`, and m2 never sees ack during m0's tenure.
- Timeout: TIMEOUT_CYCLES=8 and the slave never acks. Required: `m_err_o[owner]` and `timeout_o` are high on the 8th stalled cycle for one cycle only; after the owner drops `cyc`, the state returns to IDLE.
- Ack/drop race: the owner drops `cyc` on the same cycle as `s_ack_i`. Required: `m_ack_o`=0, and the state goes to IDLE next cycle.
- Reset mid-tenure: assert `wb_rst_i` while `grant_o`=3'b100 and stb is pending. Required: the next cycle shows all outputs 0 and `rr_ptr`=0, so the next request from m0 is granted first.
